gate_control_list: RTL and testbench
====================================

// Module: gate_control_list
// PURPOSE
// - 802.1Qbv time-aware gate generator for one egress port, placed directly upstream of transmission_selection.
// - Walks a programmable gate control list (GCL) against sync_time_ptp_ns.
// - Produces the 8-bit per-queue gate-open mask plus the time left in the current entry.
// - transmission_selection consumes the mask for queue eligibility and the remaining time for guard-band decisions.
// PARAMETERS
// - MAX_ENTRIES    16  GCL depth (power of two, 2..64).
// - ENTRY_IDX_W    4   log2(MAX_ENTRIES).
// - CLK_PERIOD_NS  8   ns advanced by sync_time_ptp_ns per clk.
// - DEFAULT_GATES  8'hFF  mask driven while not running.
// PORTS
// - clk                clk  1   clock, 125 MHz.
// - reset              in   1   asynchronous, active-high.
// - sync_time_ptp_ns   in   32  PTP nanoseconds, 0..999_999_999, +CLK_PERIOD_NS per clk, wraps to 0.
// - cfg_enable         in   1   level; 1 = arm/run the schedule, 0 = stop.
// - cfg_base_ns        in   32  schedule start instant (ns field).
// - cfg_num_entries    in   ENTRY_IDX_W+1  active entries, 1..MAX_ENTRIES; 0 treated as 1.
// - cfg_wr_en          in   1   single-cycle GCL write strobe.
// - cfg_wr_addr        in   ENTRY_IDX_W  entry index.
// - cfg_wr_data        in   32  [31:24] gate mask (bit q = queue q open), [23:0] interval ns.
// - cfg_commit         in   1   pulse; used only with GCL_SHADOW_EN.
// - gate_state         out  8   current open mask to transmission_selection.
// - gate_remaining_ns  out  24  ns until the current entry ends.
// - cur_entry          out  ENTRY_IDX_W  index of the active entry.
// - running            out  1   1 while in RUN.
// - cfg_pending        out  1   committed shadow table awaiting swap (0 when feature compiled out).
// BEHAVIOUR
// - Reset values: gate_state=DEFAULT_GATES, gate_remaining_ns=0, cur_entry=0, running=0, cfg_pending=0. FSM=IDLE.
// - GCL RAM contents are not reset.
// - FSM IDLE: outputs hold their reset values. cfg_enable=1 -> WAIT_BASE.
// - FSM WAIT_BASE: hit when ((sync_time_ptp_ns - cfg_base_ns) mod 1e9) < CLK_PERIOD_NS. Compute the difference in 31 bits and add 1e9 if negative, so base crossing works across the 999_999_999->0 wrap.
// - On hit: -> RUN and load entry 0. On the next cycle gate_state=mask[0], gate_remaining_ns=interval[0], running=1, cur_entry=0.
// - FSM RUN: gate_remaining_ns decrements by CLK_PERIOD_NS each clk.
// - When gate_remaining_ns <= CLK_PERIOD_NS, load entry cur_entry+1. The index wraps to 0 after cfg_num_entries-1.
// - The new mask and interval appear on the following edge, giving back-to-back entries with no gap cycle.
// - An interval < CLK_PERIOD_NS (including 0) is held for exactly one clk.
// - Arithmetic is unsigned 24-bit; the decrement never underflows because it reloads instead.
// - cfg_enable=0 in WAIT_BASE or RUN: -> IDLE on the next edge. All outputs return to reset values the same edge.
// - Re-enable waits for a fresh base hit; the schedule is never resumed mid-list.
// - cfg_num_entries changed while running: sampled only at wrap, so the cycle in progress completes unchanged.
// - Reset mid-operation: asynchronous return to IDLE and reset values.
// - Write vs read collision: a write to the entry being loaded in the same cycle is seen on the next load, never the current one.
// CONFIGURATION
// - GCL_SHADOW_EN defined: two GCL banks, active and shadow. cfg_wr_* always write the shadow bank.
//   - cfg_commit sets cfg_pending=1. Banks swap when the index wraps to 0 (or on the base hit), then cfg_pending clears that edge.
//   - cfg_commit while pending: no effect. cfg_commit in IDLE: immediate swap.
// - GCL_SHADOW_EN undefined: single bank. Writes take effect on the next load of that entry. cfg_commit is ignored; cfg_pending is tied to 0.
// TESTING
// - Basic run: reset with time=999_999_000, base=24, entries {FF/80ns, 01/40ns, FE/16ns}, enable -> running at time 24. Then gate_state FF for 10 clks, 01 for 5, FE for 2, then FF again.
// - Wrap: base=999_999_992 with time starting at 999_999_000 -> hit exactly once, at time 999_999_992. No second hit after 0.
// - Short intervals: entries with 0 ns and 5 ns -> each holds exactly 1 clk. gate_remaining_ns never exceeds the loaded value and never underflows.
// - Disable mid-run: cfg_enable=0 during entry 1 -> next clk gate_state=FF, running=0, cur_entry=0. Re-enable waits for the next base hit.
// - Shadow swap (GCL_SHADOW_EN): rewrite entry 0 to 0F/8ns and commit mid-cycle -> cfg_pending=1 until the wrap. The first wrapped entry shows 0F.
// - Without the macro, the same rewrite shows 0F on the next load of entry 0.
// - Async reset asserted mid-RUN -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/gate_control_list.sv
// gate_control_list: 802.1Qbv time-aware gate generator that walks a programmable gate
// control list against PTP time. Define GCL_SHADOW_EN for a double-buffered (active/shadow) GCL.
module gate_control_list #(
  parameter int unsigned MAX_ENTRIES   = 16,
  parameter int unsigned ENTRY_IDX_W   = 4,
  parameter int unsigned CLK_PERIOD_NS = 8,
  parameter logic [7:0]  DEFAULT_GATES = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            sync_time_ptp_ns,
  input  logic                   cfg_enable,
  input  logic [31:0]            cfg_base_ns,
  input  logic [ENTRY_IDX_W:0]   cfg_num_entries,
  input  logic                   cfg_wr_en,
  input  logic [ENTRY_IDX_W-1:0] cfg_wr_addr,
  input  logic [31:0]            cfg_wr_data,
  input  logic                   cfg_commit,
  output logic [7:0]             gate_state,
  output logic [23:0]            gate_remaining_ns,
  output logic [ENTRY_IDX_W-1:0] cur_entry,
  output logic                   running,
  output logic                   cfg_pending
);
  localparam logic signed [32:0] NS_PER_SEC  = 33'sd1_000_000_000;
  localparam logic signed [32:0] PERIOD_S    = $signed(33'(CLK_PERIOD_NS));
  localparam logic [23:0]        PERIOD_NS24 = 24'(CLK_PERIOD_NS);
  localparam logic [ENTRY_IDX_W:0] NUM_ONE   = (ENTRY_IDX_W+1)'(1);
  localparam logic [ENTRY_IDX_W:0] NUM_MAX   = (ENTRY_IDX_W+1)'(MAX_ENTRIES);

  typedef enum logic [1:0] {IDLE, WAIT_BASE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             gate_q, gate_d;
  logic [23:0]            rem_q, rem_d;
  logic [ENTRY_IDX_W-1:0] cur_q, cur_d;
  logic [ENTRY_IDX_W:0]   num_q, num_d;
  logic                   load;
  logic [ENTRY_IDX_W-1:0] load_idx;
  logic [31:0]            rd_word;

  // The base is hit when (now - base) mod 1e9 falls inside the current clock period,
  // which keeps the comparison correct across the 999_999_999 -> 0 seconds rollover.
  function automatic logic base_hit(input logic [31:0] now_ns, input logic [31:0] base_ns);
    logic signed [32:0] diff;
    diff = $signed({1'b0, now_ns}) - $signed({1'b0, base_ns});
    if (diff < 0) diff = diff + NS_PER_SEC;
    return diff < PERIOD_S;
  endfunction

  function automatic logic [ENTRY_IDX_W:0] eff_num(input logic [ENTRY_IDX_W:0] n);
    if (n == '0) return NUM_ONE;
    if (n > NUM_MAX) return NUM_MAX;
    return n;
  endfunction

`ifdef GCL_SHADOW_EN
  logic [31:0] gcl_mem [2*MAX_ENTRIES];
  logic        active_q, active_d;
  logic        pending_q, pending_d;
  logic        swap;

  always_ff @(posedge clk) begin
    if (cfg_wr_en) gcl_mem[{~active_q, cfg_wr_addr}] <= cfg_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign cfg_pending = pending_q;
`else
  logic [31:0] gcl_mem [MAX_ENTRIES];
  logic        unused_commit;

  always_ff @(posedge clk) begin
    if (cfg_wr_en) gcl_mem[cfg_wr_addr] <= cfg_wr_data;
  end

  assign unused_commit = cfg_commit;
  assign cfg_pending   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    rem_d    = rem_q;
    cur_d    = cur_q;
    num_d    = num_q;
    load     = 1'b0;
    load_idx = '0;

    case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = WAIT_BASE;
      end
      WAIT_BASE: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (base_hit(sync_time_ptp_ns, cfg_base_ns)) begin
          state_d = RUN;
          load    = 1'b1;
          num_d   = eff_num(cfg_num_entries);
        end
      end
      RUN: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (rem_q <= PERIOD_NS24) begin
          // Reload instead of decrementing so the counter never underflows; the
          // entry count is only re-sampled when the list wraps back to entry 0.
          load = 1'b1;
          if ({1'b0, cur_q} == num_q - NUM_ONE) num_d = eff_num(cfg_num_entries);
          else load_idx = cur_q + 1'b1;
        end else begin
          rem_d = rem_q - PERIOD_NS24;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef GCL_SHADOW_EN
    swap      = 1'b0;
    pending_d = pending_q;
    if (state_q == IDLE) swap = cfg_commit;
    else if (pending_q && ((load && load_idx == '0) || state_d == IDLE)) swap = 1'b1;
    else if (cfg_commit) pending_d = 1'b1;
    if (swap) pending_d = 1'b0;
    active_d = active_q ^ swap;
    // A swap coinciding with a load must already read the newly active bank.
    rd_word  = gcl_mem[{active_d, load_idx}];
`else
    rd_word  = gcl_mem[load_idx];
`endif

    if (load) begin
      gate_d = rd_word[31:24];
      rem_d  = rd_word[23:0];
      cur_d  = load_idx;
    end

    if (state_d != RUN) begin
      gate_d = DEFAULT_GATES;
      rem_d  = '0;
      cur_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= DEFAULT_GATES;
      rem_q   <= '0;
      cur_q   <= '0;
      num_q   <= NUM_ONE;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      rem_q   <= rem_d;
      cur_q   <= cur_d;
      num_q   <= num_d;
    end
  end

  assign gate_state        = gate_q;
  assign gate_remaining_ns = rem_q;
  assign cur_entry         = cur_q;
  assign running           = (state_q == RUN);

endmodule

// File: tb/tb_gate_control_list.sv
// tb_gate_control_list: directed bench for gate_control_list with a clock-count based
// reference model of the gate schedule plus hand-computed checkpoints.
module tb_gate_control_list;
  localparam int     MAXE   = 16;
  localparam int     PER    = 8;
  localparam longint NS_SEC = 1_000_000_000;
`ifdef GCL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sync_time_ptp_ns;
  logic        cfg_enable;
  logic [31:0] cfg_base_ns;
  logic [4:0]  cfg_num_entries;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_commit;
  logic [7:0]  gate_state;
  logic [23:0] gate_remaining_ns;
  logic [3:0]  cur_entry;
  logic        running;
  logic        cfg_pending;

  gate_control_list dut (
    .clk               (clk),
    .reset             (reset),
    .sync_time_ptp_ns  (sync_time_ptp_ns),
    .cfg_enable        (cfg_enable),
    .cfg_base_ns       (cfg_base_ns),
    .cfg_num_entries   (cfg_num_entries),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_wr_addr       (cfg_wr_addr),
    .cfg_wr_data       (cfg_wr_data),
    .cfg_commit        (cfg_commit),
    .gate_state        (gate_state),
    .gate_remaining_ns (gate_remaining_ns),
    .cur_entry         (cur_entry),
    .running           (running),
    .cfg_pending       (cfg_pending)
  );

  always #4 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          chk_on = 1'b0;
  longint      ptp;
  logic [31:0] t_at_edge;

  always @(posedge clk) t_at_edge = sync_time_ptp_ns;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_bank [2][MAXE];
  int          m_phase, m_idx, m_k, m_num, m_act;
  bit          m_pend;
  logic [7:0]  m_mask;
  logic [23:0] m_iv;
  logic [7:0]  exp_gate;
  logic [23:0] exp_rem;
  logic [3:0]  exp_cur;
  logic        exp_run, exp_pend;

  function automatic bit hit_m(input logic [31:0] t, input logic [31:0] b);
    longint d;
    d = (longint'(t) - longint'(b)) % NS_SEC;
    if (d < 0) d += NS_SEC;
    return d < PER;
  endfunction

  // Number of clocks an entry stays on the outputs.
  function automatic int hold_clks(input logic [23:0] iv);
    return (int'(iv) < PER) ? 1 : (int'(iv) + PER - 1) / PER;
  endfunction

  function automatic int eff_m(input logic [4:0] n);
    return (n == 5'd0) ? 1 : int'(n);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_idx = 0; m_k = 0; m_num = 1; m_act = 0; m_pend = 1'b0;
      m_mask = 8'hFF; m_iv = 24'd0;
    end else begin : model_step
      int old_phase, old_act, lidx;
      bit load, swap;
      old_phase = m_phase; old_act = m_act; lidx = 0; load = 1'b0; swap = 1'b0;
      case (m_phase)
        0: if (cfg_enable) m_phase = 1;
        1: begin
          if (!cfg_enable) m_phase = 0;
          else if (hit_m(sync_time_ptp_ns, cfg_base_ns)) begin
            m_phase = 2; load = 1'b1; m_num = eff_m(cfg_num_entries);
          end
        end
        default: begin
          if (!cfg_enable) m_phase = 0;
          else if (m_k + 1 >= hold_clks(m_iv)) begin
            load = 1'b1;
            if (m_idx == m_num - 1) m_num = eff_m(cfg_num_entries);
            else lidx = m_idx + 1;
          end else m_k++;
        end
      endcase
      if (SHADOW) begin
        if (old_phase == 0) swap = cfg_commit;
        else if (m_pend && ((load && lidx == 0) || m_phase == 0)) swap = 1'b1;
        else if (cfg_commit) m_pend = 1'b1;
        if (swap) begin m_act = 1 - m_act; m_pend = 1'b0; end
      end
      if (load) begin
        m_mask = m_bank[m_act][lidx][31:24];
        m_iv   = m_bank[m_act][lidx][23:0];
        m_idx  = lidx;
        m_k    = 0;
      end
      if (cfg_wr_en) m_bank[SHADOW ? 1 - old_act : old_act][cfg_wr_addr] = cfg_wr_data;
    end
    exp_run  = (m_phase == 2);
    exp_gate = exp_run ? m_mask : 8'hFF;
    exp_rem  = exp_run ? 24'(int'(m_iv) - PER * m_k) : 24'd0;
    exp_cur  = exp_run ? m_idx[3:0] : 4'd0;
    exp_pend = m_pend;
  end

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("model_gate", 32'(gate_state), 32'(exp_gate));
      check("model_rem", 32'(gate_remaining_ns), 32'(exp_rem));
      check("model_cur", 32'(cur_entry), 32'(exp_cur));
      check("model_running", 32'(running), 32'(exp_run));
      check("model_pending", 32'(cfg_pending), 32'(exp_pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ptp = ptp + PER;
    if (ptp >= NS_SEC) ptp = ptp - NS_SEC;
    sync_time_ptp_ns = 32'(ptp);
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic gcl_write(input int a, input logic [31:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'(a);
    cfg_wr_data = d;
    tick();
  endtask

  initial begin
    int          n, hits, max_cur;
    logic [31:0] hit_t;
    logic [7:0]  exp_g;
    bit          prev_run;
    logic [7:0]  short_g [6];
    logic [23:0] short_r [6];
    short_g = '{8'hAA, 8'h55, 8'h33, 8'h33, 8'hAA, 8'h55};
    short_r = '{24'd0, 24'd5, 24'd16, 24'd8, 24'd0, 24'd5};

    reset = 1'b1; cfg_enable = 1'b0; cfg_base_ns = 32'd24; cfg_num_entries = 5'd3;
    cfg_wr_en = 1'b0; cfg_wr_addr = 4'd0; cfg_wr_data = 32'd0; cfg_commit = 1'b0;
    ptp = 999_999_000; sync_time_ptp_ns = 32'(ptp);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_gate", 32'(gate_state), 32'hFF);
    check("rst_rem", 32'(gate_remaining_ns), 32'd0);
    check("rst_cur", 32'(cur_entry), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    chk_on = 1'b1;

    // Basic run: base 24 reached after the seconds rollover.
    gcl_write(0, 32'hFF00_0050);
    gcl_write(1, 32'h0100_0028);
    gcl_write(2, 32'hFE00_0010);
    cfg_commit = 1'b1; tick();
    cfg_enable = 1'b1;
    n = 0;
    while (!running && n < 300) begin tick(); n++; end
    check("basic_running", 32'(running), 32'd1);
    check("basic_hit_time", t_at_edge, 32'd24);
    check("basic_first_rem", 32'(gate_remaining_ns), 32'd80);
    for (int i = 0; i < 18; i++) begin
      exp_g = (i < 10) ? 8'hFF : (i < 15) ? 8'h01 : (i < 17) ? 8'hFE : 8'hFF;
      check("basic_seq", 32'(gate_state), 32'(exp_g));
      tick();
    end

    // Rewrite entry 0 mid-cycle and commit.
    n = 0;
    while (cur_entry != 4'd1 && n < 40) begin tick(); n++; end
    check("rw_reach_e1", 32'(cur_entry), 32'd1);
    gcl_write(1, 32'h0100_0028);
    gcl_write(2, 32'hFE00_0010);
    cfg_commit = 1'b1;
    gcl_write(0, 32'h0F00_0008);
    check("rw_pending", 32'(cfg_pending), 32'(SHADOW));
    n = 0;
    while (cur_entry != 4'd0 && n < 40) begin tick(); n++; end
    check("rw_wrap_gate", 32'(gate_state), 32'h0F);
    check("rw_wrap_rem", 32'(gate_remaining_ns), 32'd8);
    check("rw_wrap_pending", 32'(cfg_pending), 32'd0);
    tick();
    check("rw_after_short", 32'(gate_state), 32'h01);

    // Entry count shrinks mid-cycle: the current pass still visits entry 2.
    cfg_num_entries = 5'd2;
    n = 0;
    while (cur_entry != 4'd2 && n < 20) begin tick(); n++; end
    check("num_inflight_e2", 32'(cur_entry), 32'd2);
    n = 0;
    while (cur_entry != 4'd0 && n < 20) begin tick(); n++; end
    check("num_wrap", 32'(cur_entry), 32'd0);
    max_cur = 0;
    repeat (30) begin
      tick();
      if (int'(cur_entry) > max_cur) max_cur = int'(cur_entry);
    end
    check("num_new_len", 32'(max_cur), 32'd1);

    // Write to the entry being loaded in the same cycle.
    n = 0;
    while (!(cur_entry == 4'd1 && gate_remaining_ns == 24'd8) && n < 20) begin tick(); n++; end
    check("collide_setup", 32'(gate_remaining_ns), 32'd8);
    gcl_write(0, 32'h7700_0008);
    check("collide_current", 32'(gate_state), 32'h0F);
    tick();
    n = 0;
    while (cur_entry != 4'd0 && n < 20) begin tick(); n++; end
    check("collide_next", 32'(gate_state), SHADOW ? 32'h0F : 32'h77);

    // Disable during entry 1.
    n = 0;
    while (cur_entry != 4'd1 && n < 20) begin tick(); n++; end
    cfg_enable = 1'b0;
    tick();
    check("dis_gate", 32'(gate_state), 32'hFF);
    check("dis_running", 32'(running), 32'd0);
    check("dis_cur", 32'(cur_entry), 32'd0);
    check("dis_rem", 32'(gate_remaining_ns), 32'd0);

    // Short intervals, re-enabled against a fresh base.
    cfg_num_entries = 5'd3;
    gcl_write(0, 32'hAA00_0000);
    gcl_write(1, 32'h5500_0005);
    gcl_write(2, 32'h3300_0010);
    cfg_commit = 1'b1; tick();
    cfg_base_ns = 32'((ptp + 64) % NS_SEC);
    cfg_enable = 1'b1;
    repeat (3) tick();
    check("reenable_waits", 32'(running), 32'd0);
    n = 0;
    while (!running && n < 50) begin tick(); n++; end
    check("short_hit_time", t_at_edge, cfg_base_ns);
    for (int i = 0; i < 6; i++) begin
      check("short_gate", 32'(gate_state), 32'(short_g[i]));
      check("short_rem", 32'(gate_remaining_ns), 32'(short_r[i]));
      tick();
    end

    // Base just before the rollover: exactly one hit.
    cfg_enable = 1'b0; tick();
    ptp = 999_999_000; sync_time_ptp_ns = 32'(ptp);
    cfg_base_ns = 32'd999_999_992;
    cfg_enable = 1'b1;
    hits = 0; hit_t = 32'd0; prev_run = 1'b0;
    repeat (200) begin
      tick();
      if (running && !prev_run) begin hits++; hit_t = t_at_edge; end
      prev_run = running;
    end
    check("wrap_hits", 32'(hits), 32'd1);
    check("wrap_hit_time", hit_t, 32'd999_999_992);
    check("wrap_still_running", 32'(running), 32'd1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("areset_gate", 32'(gate_state), 32'hFF);
    check("areset_rem", 32'(gate_remaining_ns), 32'd0);
    check("areset_cur", 32'(cur_entry), 32'd0);
    check("areset_running", 32'(running), 32'd0);
    check("areset_pending", 32'(cfg_pending), 32'd0);
    cfg_enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick(); tick();
    check("post_reset_idle", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
